seg_instruction_fetch: RTL

- First pipeline stage of the MIPS core. Holds the PC, selects the next PC, reads the instruction memory and registers the IF/ID latch consumed by seg_instruction_decode (its i_PC and i_instruction).
- Supports load-use stalls, control-hazard flushes, debug enable/stepping, program loading and HALT detection.

---
 rtl/mips_pkg.sv | 10 +
 rtl/seg_instruction_fetch_imem.sv | 26 ++
 rtl/seg_instruction_fetch.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline stages.
package mips_pkg;

    localparam int          LEN          = 32;
    localparam int          NB_IMEM_ADDR = 10;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/seg_instruction_fetch_imem.sv
// Instruction memory: word array, asynchronous read, synchronous write.
// Contents are not reset, so a loaded program survives a core reset.
module instruction_memory #(
    parameter int NB_ADDR = 10,
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);

    logic [NB_DATA-1:0] r_mem [2**NB_ADDR];

    // Program-load write port; a same-cycle read sees the old word.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/seg_instruction_fetch.sv
// IF stage: PC register, next-PC selection, instruction memory read,
// IF/ID latch and sticky HALT flag.
module seg_instruction_fetch #(
    parameter int               LEN          = mips_pkg::LEN,
    parameter int               NB_IMEM_ADDR = mips_pkg::NB_IMEM_ADDR,
    parameter logic [LEN-1:0]   HALT_INSTR   = LEN'(mips_pkg::HALT_INSTR)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_branch,
    input  logic [LEN-1:0]          i_PC_branch,
    input  logic                    i_jump_register,
    input  logic [LEN-1:0]          i_PC_register,
    input  logic                    i_jump,
    input  logic [LEN-1:0]          i_PC_dir_jump,
    input  logic                    i_wr_en,
    input  logic [NB_IMEM_ADDR-1:0] i_wr_addr,
    input  logic [LEN-1:0]          i_wr_data,
    output logic [LEN-1:0]          o_PC,
    output logic [LEN-1:0]          o_instruction,
    output logic                    o_halt,
    output logic [LEN-1:0]          o_PC_current
);

    import mips_pkg::*;

    logic [LEN-1:0]          r_pc;
    logic [LEN-1:0]          r_ifid_pc;
    logic [LEN-1:0]          r_ifid_instr;
    logic                    r_halt;

    logic [LEN-1:0]          w_pc_plus4;
    logic [LEN-1:0]          w_pc_next;
    logic [LEN-1:0]          w_fetch;
    logic                    w_is_halt;
    logic [NB_IMEM_ADDR-1:0] w_rd_addr;

    // Byte address to word index; upper PC bits drop out, so the index wraps.
    assign w_rd_addr = r_pc[NB_IMEM_ADDR+1:2];

    instruction_memory #(
        .NB_ADDR (NB_IMEM_ADDR),
        .NB_DATA (LEN)
    ) u_imem (
        .i_clk     (i_clk),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_fetch)
    );

    assign w_pc_plus4 = r_pc + LEN'(PC_STEP);
    assign w_is_halt  = (w_fetch == HALT_INSTR);

    // Next-PC select: branch over register jump over direct jump over PC+4.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (i_branch) begin
            w_pc_next = i_PC_branch;
        end else if (i_jump_register) begin
            w_pc_next = i_PC_register;
        end else if (i_jump) begin
            w_pc_next = i_PC_dir_jump;
        end
    end

    // PC, IF/ID latch and halt flag; flush beats halt beats stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= '0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= LEN'(NOP_INSTR);
            r_halt       <= 1'b0;
        end else if (i_enable) begin
            if (i_flush) begin
                r_ifid_pc    <= '0;
                r_ifid_instr <= LEN'(NOP_INSTR);
                r_pc         <= w_pc_next;
            end else if (r_halt) begin
                r_ifid_pc    <= '0;
                r_ifid_instr <= LEN'(NOP_INSTR);
            end else if (!i_stall) begin
                r_ifid_pc    <= w_pc_plus4;
                r_ifid_instr <= w_fetch;
                if (w_is_halt) begin
                    r_halt <= 1'b1;
                end else begin
                    r_pc <= w_pc_next;
                end
            end
        end
    end

    assign o_PC          = r_ifid_pc;
    assign o_instruction = r_ifid_instr;
    assign o_halt        = r_halt;
    assign o_PC_current  = r_pc;

endmodule
